cost_request_sequencer: RTL and testbench
=========================================

# cost_request_sequencer

Initiator side of the cost calculator's `cost_en` / `calculation_complete` handshake. It collects ten 4-bit digit confidences serially from the output layer, plus one binary-coded expected label. It then presents them as a one-hot label vector and a packed weight array, fires a single-cycle `cost_en`, and waits for completion. It captures the returned 8-bit cost and reports it with a one-cycle valid strobe, along with the argmax-predicted digit.

## Interface
- `TIMEOUT_CYCLES`, default 63: maximum cycles spent in WAIT before a timeout, counted from the cycle after `cost_en`. Used only when the watchdog is compiled in.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `n_rst`  in  1  asynchronous, active-low reset.
- `digit_valid`  in  1  strobe; `digit_value` is accepted this cycle.
- `digit_value`  in  4  confidence of the next digit, presented in index order 0..9.
- `label_valid`  in  1  strobe; `label_digit` is accepted this cycle.
- `label_digit`  in  4  expected digit, binary coded 0..9.
- `calculation_complete`  in  1  responder's done pulse.
- `cost_output`  in  8  responder's cost; valid while `calculation_complete` is high.
- `cost_en`  out  1  one-cycle request pulse to the responder.
- `expected_label`  out  [0:9]  one-hot label; bit k is 1 when the label equals k.
- `digit_weights`  out  [0:9][3:0]  collected confidences; entry k is digit k.
- `cost_valid`  out  1  one-cycle pulse; `cost_result` was updated in this cycle.
- `cost_result`  out  8  last captured cost.
- `predicted_digit`  out  4  index of the maximum confidence among the 10 collected digits.
- `busy`  out  1  high from the first digit accepted through the `cost_valid` cycle.
- `label_error`  out  1  sticky; set when the last label presented was greater than 9.
- `timeout`  out  1  sticky watchdog flag. Tied to 0 when the watchdog is compiled out.
- All outputs reset to 0.

## Operation
- States: IDLE, COLLECT, REQUEST, WAIT, DONE.
- **IDLE**
  - `digit_valid` stores the digit at index 0, sets the index to 1, raises `busy` and moves to COLLECT.
  - The label flag clears on entry to IDLE, so each request needs a fresh label.
- **COLLECT**
  - Each `digit_valid` stores `digit_value` at the current index, then the index increments.
  - The argmax tracker updates on every accepted digit:
    - a strictly greater value replaces the current maximum;
    - on ties the lower index is kept.
- **Labels**
  - `label_valid` is accepted in IDLE or COLLECT.
  - A value of 0..9 loads the one-hot `expected_label`, sets the label flag and clears `label_error`.
  - A value greater than 9 sets `label_error`, clears the label flag and leaves `expected_label` unchanged.
  - A later valid label overwrites an earlier one.
  - `label_valid` and `digit_valid` may be high in the same cycle; both are accepted.
- **COLLECT → REQUEST** when the tenth digit has been accepted and the label flag is set. Otherwise the block holds in COLLECT; further `digit_valid` pulses are ignored.
- **REQUEST**: `cost_en` is 1 for exactly one cycle, then the block moves to WAIT.
- **WAIT**
  - `expected_label` and `digit_weights` are held constant from REQUEST until the block leaves WAIT.
  - When `calculation_complete` is sampled high, `cost_output` is loaded into `cost_result` and the block moves to DONE.
- **DONE**: `cost_valid` is 1 for one cycle, `busy` is 0 on the next cycle, and the block returns to IDLE.
- **Ignored inputs**
  - `digit_valid` and `label_valid` are ignored in REQUEST, WAIT and DONE.
  - `calculation_complete` is ignored outside WAIT.
- **Reset mid-operation**: all state returns to IDLE, the collected data is discarded and every output goes to 0.

## Timing
- `cost_en` rises in the cycle after the later of two edges: the tenth digit being accepted, or the valid label being accepted.
- `cost_result` and `cost_valid` change on the edge after the cycle in which `calculation_complete` is high. The cost is therefore visible one cycle after the completion pulse.
- `predicted_digit` is final in the cycle after the tenth digit is accepted. It holds until the first digit of the next frame.
- Minimum frame time: 10 collect cycles, then REQUEST (1), then the responder's latency, then DONE (1).

## Configuration
- `COST_REQ_TIMEOUT_EN`
  - **Defined**: a 6-bit watchdog counts cycles in WAIT.
    - When the count reaches `TIMEOUT_CYCLES` without completion, `timeout` is set and the block moves to DONE.
    - In this case `cost_result` is left unchanged and `cost_valid` still pulses.
    - `timeout` clears on the next REQUEST.
  - **Undefined**: WAIT holds indefinitely, no counter is built, and `timeout` is constantly 0.

## Test plan
- **Match case**: label 3; digits all 0 except index 3 = 8; real cost calculator attached.
  → one `cost_en` pulse, `expected_label` = 0001000000, `cost_result` = 0, `predicted_digit` = 3.
- **Mismatch case**: label 3; all digits 0.
  → `cost_result` = 16, `cost_valid` one cycle, `predicted_digit` = 0 (tie keeps the lowest index).
- **Late label**: ten digits sent, label 7 sent five cycles later.
  → `cost_en` rises exactly one cycle after the label is accepted; extra `digit_valid` pulses are ignored.
- **Bad label**: label 12 sent, then label 5.
  → `label_error` = 1 and no request; then `label_error` = 0 and `cost_en` fires with `expected_label` bit 5 set.
- **Reset in WAIT**: `n_rst` pulsed low while in WAIT.
  → all outputs 0 immediately; a new frame completes normally afterwards.
- **Timeout**: `COST_REQ_TIMEOUT_EN` defined, stub responder that never completes.
  → `timeout` = 1 and `cost_valid` pulses 63 cycles after `cost_en`; `cost_result` is unchanged.

Source files
------------

// File: rtl/cost_request_sequencer_if.sv
// Signal bundle between the output layer / cost calculator and cost_request_sequencer.
// master is the sequencer's view; slave is the environment's view.
interface cost_request_sequencer_if;
    logic            digit_valid;
    logic [3:0]      digit_value;
    logic            label_valid;
    logic [3:0]      label_digit;
    logic            calculation_complete;
    logic [7:0]      cost_output;
    logic            cost_en;
    logic [0:9]      expected_label;
    logic [0:9][3:0] digit_weights;
    logic            cost_valid;
    logic [7:0]      cost_result;
    logic [3:0]      predicted_digit;
    logic            busy;
    logic            label_error;
    logic            timeout;

    modport master (
        input  digit_valid, digit_value, label_valid, label_digit,
               calculation_complete, cost_output,
        output cost_en, expected_label, digit_weights, cost_valid,
               cost_result, predicted_digit, busy, label_error, timeout
    );

    modport slave (
        output digit_valid, digit_value, label_valid, label_digit,
               calculation_complete, cost_output,
        input  cost_en, expected_label, digit_weights, cost_valid,
               cost_result, predicted_digit, busy, label_error, timeout
    );
endinterface

// File: rtl/cost_request_sequencer.sv
// Gathers ten digit confidences plus a label, issues one cost_en request and reports the cost.
// Optional watchdog in WAIT: COST_REQ_TIMEOUT_EN (TIMEOUT_CYCLES exists only then, range 1..63).

module cost_request_sequencer_lane #(
    parameter int VEC_W = 4
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             load,
    input  logic [VEC_W-1:0] din,
    output logic [VEC_W-1:0] q
);
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)    q <= '0;
        else if (load) q <= din;
    end
endmodule

module cost_request_sequencer
`ifdef COST_REQ_TIMEOUT_EN
    #(parameter int unsigned TIMEOUT_CYCLES = 63)
`endif
(
    input logic                      clk,
    input logic                      n_rst,
    cost_request_sequencer_if.master bus
);
    localparam int         NUM_LANES = 10;
    localparam int         VEC_W     = 4;
    localparam logic [3:0] LAST_IDX  = 4'(NUM_LANES - 1);
    localparam logic [3:0] FULL_IDX  = 4'(NUM_LANES);

    typedef enum logic [2:0] {
        S_IDLE, S_COLLECT, S_REQUEST, S_WAIT, S_DONE
    } state_t;

    state_t                          state, state_nxt;
    logic [3:0]                      idx, wr_idx;
    logic                            digit_acc, label_acc, label_good;
    logic                            label_ok, label_ok_nxt, digits_done_nxt;
    logic [0:NUM_LANES-1]            label_onehot, expected_label;
    logic [0:NUM_LANES-1][VEC_W-1:0] weights;
    logic [VEC_W-1:0]                max_val;
    logic [3:0]                      pred;
    logic [7:0]                      cost_result;
    logic                            label_error;
    logic                            wd_fire;

    assign digit_acc  = bus.digit_valid &&
                        (state == S_IDLE || (state == S_COLLECT && idx != FULL_IDX));
    assign label_acc  = bus.label_valid && (state == S_IDLE || state == S_COLLECT);
    assign label_good = bus.label_digit <= 4'd9;
    assign wr_idx     = (state == S_IDLE) ? 4'd0 : idx;

    // Look-ahead so the request leaves the same edge that accepts the last digit or label.
    assign label_ok_nxt    = label_acc ? label_good : label_ok;
    assign digits_done_nxt = (idx == FULL_IDX) || (digit_acc && idx == LAST_IDX);

    always_comb begin
        label_onehot = '0;
        for (int k = 0; k < NUM_LANES; k++)
            label_onehot[k] = (bus.label_digit == 4'(k));
    end

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        cost_request_sequencer_lane #(.VEC_W(VEC_W)) u_lane (
            .clk   (clk),
            .n_rst (n_rst),
            .load  (digit_acc && wr_idx == 4'(k)),
            .din   (bus.digit_value),
            .q     (weights[k])
        );
    end

`ifdef COST_REQ_TIMEOUT_EN
    localparam logic [5:0] WD_LAST = 6'(TIMEOUT_CYCLES - 1);
    logic [5:0] wd_cnt;
    logic       timeout;

    // wd_cnt = cycles elapsed since cost_en, so DONE lands TIMEOUT_CYCLES cycles after it.
    assign wd_fire = (state == S_WAIT) && !bus.calculation_complete && (wd_cnt >= WD_LAST);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wd_cnt  <= '0;
            timeout <= 1'b0;
        end else begin
            if (state == S_REQUEST)   wd_cnt <= 6'd1;
            else if (state == S_WAIT) wd_cnt <= wd_cnt + 6'd1;
            if (state_nxt == S_REQUEST) timeout <= 1'b0;
            else if (wd_fire)           timeout <= 1'b1;
        end
    end

    assign bus.timeout = timeout;
`else
    assign wd_fire     = 1'b0;
    assign bus.timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (digit_acc) state_nxt = S_COLLECT;
            S_COLLECT: if (digits_done_nxt && label_ok_nxt) state_nxt = S_REQUEST;
            S_REQUEST: state_nxt = S_WAIT;
            S_WAIT:    if (bus.calculation_complete || wd_fire) state_nxt = S_DONE;
            S_DONE:    state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        bus.cost_en    = 1'b0;
        bus.cost_valid = 1'b0;
        bus.busy       = 1'b0;
        case (state)
            S_COLLECT: bus.busy = 1'b1;
            S_REQUEST: begin bus.busy = 1'b1; bus.cost_en = 1'b1; end
            S_WAIT:    bus.busy = 1'b1;
            S_DONE:    begin bus.busy = 1'b1; bus.cost_valid = 1'b1; end
            default:   ;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            idx            <= '0;
            label_ok       <= 1'b0;
            expected_label <= '0;
            label_error    <= 1'b0;
            max_val        <= '0;
            pred           <= '0;
            cost_result    <= '0;
        end else begin
            if (digit_acc)            idx <= wr_idx + 4'd1;
            else if (state == S_DONE) idx <= '0;

            // Each frame needs its own label: the flag drops on the way back to IDLE.
            label_ok <= (state == S_DONE) ? 1'b0 : label_ok_nxt;

            if (label_acc) begin
                if (label_good) begin
                    expected_label <= label_onehot;
                    label_error    <= 1'b0;
                end else begin
                    label_error    <= 1'b1;
                end
            end

            // Strictly-greater replace keeps the lowest index on ties.
            if (digit_acc && (state == S_IDLE || bus.digit_value > max_val)) begin
                max_val <= bus.digit_value;
                pred    <= wr_idx;
            end

            if (state == S_WAIT && bus.calculation_complete)
                cost_result <= bus.cost_output;
        end
    end

    assign bus.expected_label  = expected_label;
    assign bus.digit_weights   = weights;
    assign bus.cost_result     = cost_result;
    assign bus.predicted_digit = pred;
    assign bus.label_error     = label_error;
endmodule

// File: tb/tb_cost_request_sequencer.sv
// Random frames for cost_request_sequencer; the bench plays output layer and cost calculator,
// queues expected frames/costs at issue time and a monitor checks them when the DUT strobes.
module tb_cost_request_sequencer;
    logic clk   = 1'b0;
    logic n_rst = 1'b0;

    cost_request_sequencer_if bus();

    cost_request_sequencer dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [0:9]      lab;
        logic [0:9][3:0] w;
        logic [3:0]      pred;
        int              en_cyc;
    } frame_t;

    frame_t     frame_q[$];
    frame_t     cur;
    logic [7:0] cost_q[$];
    int         vcyc_q[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc    = 0;
    logic       hold   = 1'b0;
    logic [7:0] last_cost = 8'd0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_data"}, 64'({bus.expected_label, bus.digit_weights}), 64'd0);
        chk({name, "_ctrl"}, 64'({bus.cost_en, bus.cost_valid, bus.cost_result, bus.predicted_digit,
                                  bus.busy, bus.label_error, bus.timeout}), 64'd0);
    endtask

    task automatic tick();
        @(negedge clk);
        bus.digit_valid = 1'b0;
        bus.label_valid = 1'b0;
    endtask

    // mode 0: label before digits, 1: label together with a digit,
    //      2: label after digits (extra digits in between), 3: bad label first, good label late
    task automatic run_frame(input logic [0:9][3:0] w, input logic [3:0] lab, input int mode,
                             input bit wait_done);
        frame_t f;
        int     lslot, n, dcyc, lcyc;
        f.w   = w;
        f.lab = '0;
        f.lab[lab] = 1'b1;
        f.pred = 4'd0;
        for (int k = 1; k < 10; k++)
            if (w[k] > w[f.pred]) f.pred = 4'(k);
        lslot = (mode == 1) ? int'($urandom_range(0, 9)) : -1;
        dcyc  = 0;
        lcyc  = 0;

        if (mode == 0 || mode == 3) begin
            tick();
            bus.label_valid = 1'b1;
            bus.label_digit = (mode == 3) ? 4'($urandom_range(10, 15)) : lab;
            lcyc = cyc;
            if (mode == 3) begin
                tick();
                chk("label_error_set", 64'(bus.label_error), 64'd1);
            end
        end

        for (int k = 0; k < 10; k++) begin
            n = $urandom_range(0, 2);
            repeat (n) tick();
            tick();
            bus.digit_valid = 1'b1;
            bus.digit_value = w[k];
            if (k == lslot) begin
                bus.label_valid = 1'b1;
                bus.label_digit = lab;
                lcyc = cyc;
            end
            if (k == 9) dcyc = cyc;
        end

        if (mode >= 2) begin
            n = $urandom_range(1, 6);
            repeat (n) begin
                tick();
                if ($urandom_range(0, 1) == 1) begin
                    bus.digit_valid = 1'b1;
                    bus.digit_value = 4'($urandom);
                end
            end
            tick();
            bus.label_valid = 1'b1;
            bus.label_digit = lab;
            lcyc = cyc;
        end

        f.en_cyc = ((dcyc > lcyc) ? dcyc : lcyc) + 1;
        frame_q.push_back(f);

        if (mode == 3) begin
            tick();
            chk("label_error_clear", 64'(bus.label_error), 64'd0);
        end

        if (wait_done) begin
            n = 0;
            while (!bus.cost_valid && n < 300) begin
                tick();
                n++;
                if (!bus.cost_valid && $urandom_range(0, 3) == 0) begin
                    bus.digit_valid = 1'b1;
                    bus.digit_value = 4'($urandom);
                    bus.label_valid = 1'b1;
                    bus.label_digit = 4'($urandom);
                end
            end
            if (!bus.cost_valid) begin
                checks++;
                errors++;
                $display("FAIL frame_done: no cost_valid within %0d cycles (cycle %0d)", n, cyc);
            end
        end
    endtask

    task automatic rand_frame(input int mode, input bit wait_done);
        logic [0:9][3:0] w;
        for (int k = 0; k < 10; k++)
            w[k] = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 3)) : 4'($urandom);
        run_frame(w, 4'($urandom_range(0, 9)), mode, wait_done);
    endtask

    task automatic wait_cost_en();
        int n;
        n = 0;
        while (!bus.cost_en && n < 100) begin
            tick();
            n++;
        end
        if (!bus.cost_en) begin
            checks++;
            errors++;
            $display("FAIL wait_cost_en: no request within %0d cycles (cycle %0d)", n, cyc);
        end
    endtask

    // Responder: completes 1..6 WAIT cycles after cost_en; also sends stray pulses outside WAIT.
    initial begin
        bit         pending;
        int         cnt;
        logic [7:0] c;
        pending = 1'b0;
        cnt     = 0;
        bus.calculation_complete = 1'b0;
        bus.cost_output          = 8'd0;
        forever begin
            @(negedge clk);
            bus.calculation_complete = 1'b0;
            if (!n_rst || bus.cost_valid) pending = 1'b0;
            if (pending && !hold) begin
                if (cnt == 0) begin
                    c = 8'($urandom);
                    bus.cost_output          = c;
                    bus.calculation_complete = 1'b1;
                    cost_q.push_back(c);
                    vcyc_q.push_back(cyc + 1);
                    pending = 1'b0;
                end else begin
                    cnt--;
                end
            end else if (!pending && !hold && $urandom_range(0, 9) == 0) begin
                bus.cost_output          = 8'($urandom);
                bus.calculation_complete = 1'b1;
            end
            if (n_rst && bus.cost_en) begin
                pending = 1'b1;
                cnt     = $urandom_range(0, 5);
            end
        end
    end

    // Monitor
    initial begin
        bit         prev_en, prev_valid;
        logic [7:0] c;
        int         vc;
        prev_en    = 1'b0;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (!n_rst) begin
                prev_en    = 1'b0;
                prev_valid = 1'b0;
            end else begin
                if (prev_en)    chk("cost_en_width", 64'(bus.cost_en), 64'd0);
                if (prev_valid) chk("idle_after_done", 64'({bus.busy, bus.cost_valid}), 64'd0);
                if (bus.cost_en) begin
                    if (frame_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_cost_en: got 1 expected 0 (cycle %0d)", cyc);
                    end else begin
                        cur = frame_q.pop_front();
                        chk("cost_en_cycle", 64'(cyc), 64'(cur.en_cyc));
                        chk("expected_label", 64'(bus.expected_label), 64'(cur.lab));
                        chk("digit_weights", 64'(bus.digit_weights), 64'(cur.w));
                        chk("predicted_digit", 64'(bus.predicted_digit), 64'(cur.pred));
                        chk("busy_request", 64'(bus.busy), 64'd1);
                    end
                end
                if (bus.cost_valid) begin
                    if (cost_q.size() != 0) begin
                        c  = cost_q.pop_front();
                        vc = vcyc_q.pop_front();
                        chk("cost_result", 64'(bus.cost_result), 64'(c));
                        chk("cost_valid_cycle", 64'(cyc), 64'(vc));
                        chk("timeout_clear", 64'(bus.timeout), 64'd0);
                        last_cost = c;
                    end else begin
                        chk("cost_result_held", 64'(bus.cost_result), 64'(last_cost));
                        chk("timeout_set", 64'(bus.timeout), 64'd1);
                    end
                    chk("label_held", 64'(bus.expected_label), 64'(cur.lab));
                    chk("weights_held", 64'(bus.digit_weights), 64'(cur.w));
                    chk("pred_held", 64'(bus.predicted_digit), 64'(cur.pred));
                    chk("busy_done", 64'(bus.busy), 64'd1);
                end
                prev_en    = bus.cost_en;
                prev_valid = bus.cost_valid;
            end
        end
    end

    initial begin
        logic [0:9][3:0] w;
`ifdef COST_REQ_TIMEOUT_EN
        int en_c, n;
`endif
        bus.digit_valid = 1'b0;
        bus.digit_value = 4'd0;
        bus.label_valid = 1'b0;
        bus.label_digit = 4'd0;
        #1;
        chk_all_zero("reset");
        repeat (3) @(negedge clk);
        n_rst = 1'b1;

        w = '0;
        w[3] = 4'd8;
        run_frame(w, 4'd3, 0, 1'b1);            // match case
        w = '0;
        run_frame(w, 4'd3, 1, 1'b1);            // all zero: tie keeps index 0
        for (int k = 0; k < 10; k++) w[k] = 4'($urandom);
        run_frame(w, 4'd7, 2, 1'b1);            // late label
        run_frame(w, 4'd5, 3, 1'b1);            // bad label then good label
        w = '0;
        w[9] = 4'd15;
        run_frame(w, 4'd0, 0, 1'b1);            // max at the last index

        for (int i = 0; i < 40; i++) rand_frame(int'($urandom_range(0, 3)), 1'b1);

        // Reset while the request is outstanding
        hold = 1'b1;
        rand_frame(int'($urandom_range(0, 3)), 1'b0);
        wait_cost_en();
        repeat (3) tick();
        n_rst = 1'b0;
        #1;
        chk_all_zero("reset_in_wait");
        frame_q.delete();
        cost_q.delete();
        vcyc_q.delete();
        last_cost = 8'd0;
        tick();
        tick();
        n_rst = 1'b1;
        hold  = 1'b0;
        for (int i = 0; i < 6; i++) rand_frame(int'($urandom_range(0, 3)), 1'b1);

`ifdef COST_REQ_TIMEOUT_EN
        hold = 1'b1;
        rand_frame(0, 1'b0);
        wait_cost_en();
        en_c = cyc;
        n = 0;
        while (!bus.cost_valid && n < 200) begin
            tick();
            n++;
        end
        chk("timeout_latency", 64'(cyc - en_c), 64'd63);
        chk("timeout_flag", 64'(bus.timeout), 64'd1);
        hold = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) rand_frame(int'($urandom_range(0, 3)), 1'b1);
`endif

        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
